// File: rtl/mem_access_ctrl_pkg.sv
// Shared types, widths and decode helpers for the memory-stage load/store sequencer.
package mem_access_ctrl_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned OFF_W  = 3;
  localparam int unsigned MASK_W = XLEN / 8;
  localparam int unsigned CNT_W  = 8;

  localparam logic [XLEN-1:0] ZERO_WORD = '0;

  typedef enum logic [2:0] {
    MEM_OP_NONE = 3'b000,
    MEM_OP_B    = 3'b001,
    MEM_OP_H    = 3'b010,
    MEM_OP_W    = 3'b011,
    MEM_OP_BU   = 3'b100,
    MEM_OP_HU   = 3'b101,
    MEM_OP_WU   = 3'b110,
    MEM_OP_D    = 3'b111
  } mem_op_e;

  typedef enum logic [1:0] {
    MAC_IDLE = 2'd0,
    MAC_REQ  = 2'd1,
    MAC_WAIT = 2'd2,
    MAC_DONE = 2'd3
  } mac_state_e;

  typedef struct packed {
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [MASK_W-1:0] wmask;
  } ram_req_t;

  // Unsigned-extension codes only make sense for loads.
  function automatic logic op_legal(input logic store, input mem_op_e op);
    case (op)
      MEM_OP_NONE:                      return 1'b0;
      MEM_OP_BU, MEM_OP_HU, MEM_OP_WU:  return !store;
      default:                          return 1'b1;
    endcase
  endfunction

  function automatic logic op_aligned(input mem_op_e op, input logic [OFF_W-1:0] off);
    case (op)
      MEM_OP_H, MEM_OP_HU: return off[0] == 1'b0;
      MEM_OP_W, MEM_OP_WU: return off[1:0] == 2'b00;
      MEM_OP_D:            return off == 3'b000;
      default:             return 1'b1;
    endcase
  endfunction

  function automatic logic [MASK_W-1:0] lane_mask(input mem_op_e op, input logic [OFF_W-1:0] off);
    case (op)
      MEM_OP_B, MEM_OP_BU: return 8'h01 << off;
      MEM_OP_H, MEM_OP_HU: return 8'h03 << off;
      MEM_OP_W, MEM_OP_WU: return 8'h0F << off;
      MEM_OP_D:            return 8'hFF;
      default:             return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// EX-stage offer, data-RAM port and writeback beat of the memory-stage sequencer.
interface mem_access_ctrl_if;
  import mem_access_ctrl_pkg::*;

  logic            ex_valid;
  logic            ex_ready;
  logic            ex_store;
  logic [2:0]      ex_mem_op;
  logic [XLEN-1:0] ex_addr;
  logic [XLEN-1:0] ex_wdata;

  logic              ram_req_valid;
  logic              ram_req_ready;
  logic              ram_req_we;
  logic [XLEN-1:0]   ram_req_addr;
  logic [XLEN-1:0]   ram_req_wdata;
  logic [MASK_W-1:0] ram_req_wmask;
  logic              ram_resp_valid;
  logic [XLEN-1:0]   ram_resp_rdata;

  logic            wb_valid;
  logic            wb_ready;
  logic [XLEN-1:0] wb_rd_data;
  logic            wb_err;

  modport master (
    input  ex_valid, ex_store, ex_mem_op, ex_addr, ex_wdata,
    input  ram_req_ready, ram_resp_valid, ram_resp_rdata,
    input  wb_ready,
    output ex_ready,
    output ram_req_valid, ram_req_we, ram_req_addr, ram_req_wdata, ram_req_wmask,
    output wb_valid, wb_rd_data, wb_err
  );

  modport slave (
    output ex_valid, ex_store, ex_mem_op, ex_addr, ex_wdata,
    output ram_req_ready, ram_resp_valid, ram_resp_rdata,
    output wb_ready,
    input  ex_ready,
    input  ram_req_valid, ram_req_we, ram_req_addr, ram_req_wdata, ram_req_wmask,
    input  wb_valid, wb_rd_data, wb_err
  );

endinterface

// File: rtl/mem_ld_ext.sv
// Selects the addressed lane of a 64-bit read word and sign/zero-extends it.
module mem_ld_ext
  import mem_access_ctrl_pkg::*;
(
  input  logic [XLEN-1:0]  rdata,
  input  logic [OFF_W-1:0] off,
  input  mem_op_e          op,
  output logic [XLEN-1:0]  data
);

  logic [XLEN-1:0] sh;

  assign sh = rdata >> {off, 3'b000};

  always_comb begin
    data = ZERO_WORD;
    case (op)
      MEM_OP_B:  data = {{(XLEN-8){sh[7]}},   sh[7:0]};
      MEM_OP_H:  data = {{(XLEN-16){sh[15]}}, sh[15:0]};
      MEM_OP_W:  data = {{(XLEN-32){sh[31]}}, sh[31:0]};
      MEM_OP_BU: data = {{(XLEN-8){1'b0}},    sh[7:0]};
      MEM_OP_HU: data = {{(XLEN-16){1'b0}},   sh[15:0]};
      MEM_OP_WU: data = {{(XLEN-32){1'b0}},   sh[31:0]};
      MEM_OP_D:  data = sh;
      default:   data = ZERO_WORD;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store sequencer: one operation in flight, aligned onto a
// 64-bit RAM port, with a single registered writeback beat per operation.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               rst,
  mem_access_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mac_state_e        state_q, state_d;
  logic              store_q, store_d;
  mem_op_e           op_q, op_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  ram_req_t          req_q, req_d;
  logic              req_valid_q, req_valid_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_err_q, wb_err_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;

  mem_op_e           in_op;
  logic [OFF_W-1:0]  in_off;
  logic              in_ok;
  logic              accept;
  logic              timeout;
  logic [XLEN-1:0]   ld_val;

  assign in_op   = mem_op_e'(bus.ex_mem_op);
  assign in_off  = bus.ex_addr[OFF_W-1:0];
  assign in_ok   = op_legal(bus.ex_store, in_op) && op_aligned(in_op, in_off);
  assign accept  = bus.ex_valid && (state_q == MAC_IDLE);
  assign timeout = (cnt_q == CNT_LAST);

  mem_ld_ext u_ld_ext (
    .rdata (bus.ram_resp_rdata),
    .off   (off_q),
    .op    (op_q),
    .data  (ld_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MAC_IDLE;
      store_q     <= 1'b0;
      op_q        <= MEM_OP_NONE;
      off_q       <= '0;
      cnt_q       <= '0;
      req_q       <= '0;
      req_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_err_q    <= 1'b0;
      wb_data_q   <= ZERO_WORD;
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      op_q        <= op_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      req_valid_q <= req_valid_d;
      wb_valid_q  <= wb_valid_d;
      wb_err_q    <= wb_err_d;
      wb_data_q   <= wb_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MAC_IDLE: if (accept)                           state_d = in_ok ? MAC_REQ : MAC_DONE;
      MAC_REQ:  if (bus.ram_req_ready)                state_d = MAC_WAIT;
      MAC_WAIT: if (bus.ram_resp_valid || timeout)    state_d = MAC_DONE;
      MAC_DONE: if (bus.wb_ready)                     state_d = MAC_IDLE;
      default:                                        state_d = MAC_IDLE;
    endcase
  end

  // Next values of every registered output and the captured operation.
  always_comb begin
    store_d     = store_q;
    op_d        = op_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    req_valid_d = req_valid_q;
    wb_valid_d  = wb_valid_q;
    wb_err_d    = wb_err_q;
    wb_data_d   = wb_data_q;
    case (state_q)
      MAC_IDLE: begin
        if (accept) begin
          store_d = bus.ex_store;
          op_d    = in_op;
          off_d   = in_off;
          if (in_ok) begin
            req_valid_d = 1'b1;
            req_d.we    = bus.ex_store;
            req_d.addr  = {bus.ex_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
            req_d.wdata = bus.ex_wdata << {in_off, 3'b000};
            req_d.wmask = bus.ex_store ? lane_mask(in_op, in_off) : '0;
          end else begin
            wb_valid_d = 1'b1;
            wb_err_d   = 1'b1;
            wb_data_d  = ZERO_WORD;
          end
        end
      end
      MAC_REQ: begin
        if (bus.ram_req_ready) begin
          req_valid_d = 1'b0;
          cnt_d       = '0;
        end
      end
      MAC_WAIT: begin
        // A response in the final permitted cycle still beats the timeout.
        if (bus.ram_resp_valid) begin
          wb_valid_d = 1'b1;
          wb_err_d   = 1'b0;
          wb_data_d  = store_q ? ZERO_WORD : ld_val;
        end else if (timeout) begin
          wb_valid_d = 1'b1;
          wb_err_d   = 1'b1;
          wb_data_d  = ZERO_WORD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MAC_DONE: begin
        if (bus.wb_ready) wb_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.ex_ready      = (state_q == MAC_IDLE);
  assign bus.ram_req_valid = req_valid_q;
  assign bus.ram_req_we    = req_q.we;
  assign bus.ram_req_addr  = req_q.addr;
  assign bus.ram_req_wdata = req_q.wdata;
  assign bus.ram_req_wmask = req_q.wmask;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_err        = wb_err_q;
  assign bus.wb_rd_data    = wb_data_q;

endmodule
